// File: rtl/sprite_pkg.sv
// Shared definitions for sprite_color_mapper: field-select codes, the no-hit
// encoding and the per-sprite record held in the shadow and active sets.
package sprite_pkg;

    // Record fields are sized for the widest supported build; narrower builds zero-extend.
    localparam int SPR_COORD_MAX = 16;
    localparam int SPR_COLOR_MAX = 16;

    typedef enum logic [2:0] {
        FLD_X      = 3'd0,
        FLD_Y      = 3'd1,
        FLD_W      = 3'd2,
        FLD_H      = 3'd3,
        FLD_COLOR  = 3'd4,
        FLD_ENABLE = 3'd5
    } sprite_field_e;

    localparam logic [2:0] FLD_LAST = 3'd5;

    // hit_idx carries this flag in its MSB when no sprite covers the pixel
    localparam logic NO_HIT_FLAG = 1'b1;

    typedef struct packed {
        logic [SPR_COORD_MAX-1:0]   x;
        logic [SPR_COORD_MAX-1:0]   y;
        logic [SPR_COORD_MAX-1:0]   w;
        logic [SPR_COORD_MAX-1:0]   h;
        logic [3*SPR_COLOR_MAX-1:0] color;
        logic                       enable;
    } sprite_t;

endpackage

// File: rtl/sprite_hit.sv
// Combinational rectangle test for one sprite against the current pixel.
// Bounds are summed one bit wider than the fields so sprites at the right or bottom edge never wrap.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  sprite_t              spr,
    input  logic [COORD_W-1:0]   draw_x,
    input  logic [COORD_W-1:0]   draw_y,
    output logic                 hit
);

    localparam int SW = SPR_COORD_MAX + 1;

    logic [SW-1:0] px, py;
    logic [SW-1:0] x_lo, x_hi, y_lo, y_hi;

    assign px   = SW'(draw_x);
    assign py   = SW'(draw_y);
    assign x_lo = SW'(spr.x);
    assign y_lo = SW'(spr.y);
    assign x_hi = x_lo + SW'(spr.w);
    assign y_hi = y_lo + SW'(spr.h);

    // A zero width or height makes the half-open interval empty.
    assign hit = spr.enable
               && (px >= x_lo) && (px < x_hi)
               && (py >= y_lo) && (py < y_hi);

endmodule

// File: rtl/sprite_color_mapper.sv
// Two-stage sprite colour mapper: stage 1 registers per-sprite hits, stage 2
// picks the lowest-indexed hit or the background. Optional macro: COLLISION_DETECT_EN.
module sprite_color_mapper
    import sprite_pkg::*;
#(
    parameter  int NUM_SPRITES = 4,
    parameter  int COORD_W     = 10,
    parameter  int COLOR_W     = 8,
    localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [2:0]             wr_field,
    input  logic [3*COLOR_W-1:0]   wr_data,
    input  logic                   frame_start,
    input  logic [COORD_W-1:0]     DrawX,
    input  logic [COORD_W-1:0]     DrawY,
    input  logic                   pix_valid,
    output logic [COLOR_W-1:0]     Red,
    output logic [COLOR_W-1:0]     Green,
    output logic [COLOR_W-1:0]     Blue,
    output logic                   pix_valid_out,
    output logic [IDX_W:0]         hit_idx
`ifdef COLLISION_DETECT_EN
    ,
    output logic [NUM_SPRITES-1:0] collision_mask
`endif
);

    localparam int CW = 3 * COLOR_W;
    localparam logic [IDX_W:0] NO_HIT = {NO_HIT_FLAG, {IDX_W{1'b0}}};

    sprite_t shadow [NUM_SPRITES];
    sprite_t active [NUM_SPRITES];

    logic                       wr_ok;
    logic [SPR_COORD_MAX-1:0]   wr_coord;
    logic [3*SPR_COLOR_MAX-1:0] wr_color;

    assign wr_ok    = wr_en && (32'(wr_idx) < 32'(NUM_SPRITES)) && (wr_field <= FLD_LAST);
    assign wr_coord = SPR_COORD_MAX'(wr_data[COORD_W-1:0]);
    assign wr_color = (3*SPR_COLOR_MAX)'(wr_data);

    // Commit copies the pre-write shadow, so a coincident write lands one frame later.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (frame_start)
                    active[i] <= shadow[i];
                if (wr_ok && (wr_idx == IDX_W'(i))) begin
                    case (wr_field)
                        FLD_X:      shadow[i].x      <= wr_coord;
                        FLD_Y:      shadow[i].y      <= wr_coord;
                        FLD_W:      shadow[i].w      <= wr_coord;
                        FLD_H:      shadow[i].h      <= wr_coord;
                        FLD_COLOR:  shadow[i].color  <= wr_color;
                        FLD_ENABLE: shadow[i].enable <= wr_data[0];
                        default:    ;
                    endcase
                end
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_c;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .COORD_W (COORD_W)
        ) u_hit (
            .spr    (active[g]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit_c[g])
        );
    end

    // Colours are snapshotted with the hits so a commit between stages cannot mix frames.
    logic                   valid_s1;
    logic [NUM_SPRITES-1:0] hit_s1;
    logic [COORD_W-1:0]     drawx_s1;
    logic [CW-1:0]          color_s1 [NUM_SPRITES];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_s1 <= 1'b0;
            hit_s1   <= '0;
            drawx_s1 <= '0;
            for (int i = 0; i < NUM_SPRITES; i++)
                color_s1[i] <= '0;
        end else begin
            valid_s1 <= pix_valid;
            hit_s1   <= hit_c;
            drawx_s1 <= DrawX;
            for (int i = 0; i < NUM_SPRITES; i++)
                color_s1[i] <= active[i].color[CW-1:0];
        end
    end

    // Colour padding above CW is always zero; fold it so it is not left dangling.
    logic color_pad_unused;
    always_comb begin
        color_pad_unused = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++)
            color_pad_unused = color_pad_unused ^ (^active[i].color);
    end

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [CW-1:0]    sel_color;
    logic [6:0]       bg_idx;
    logic [COLOR_W-1:0] bg_red;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_color = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_color = color_s1[i];
            end
        end
    end

    assign bg_idx = 7'(drawx_s1 >> 3);
    assign bg_red = COLOR_W'(8'h4F) - COLOR_W'(bg_idx);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red           <= '0;
            Green         <= '0;
            Blue          <= '0;
            pix_valid_out <= 1'b0;
            hit_idx       <= NO_HIT;
        end else begin
            pix_valid_out <= valid_s1;
            if (sel_found) begin
                Red     <= sel_color[3*COLOR_W-1 -: COLOR_W];
                Green   <= sel_color[2*COLOR_W-1 -: COLOR_W];
                Blue    <= sel_color[COLOR_W-1:0];
                hit_idx <= {1'b0, sel_idx};
            end else begin
                Red     <= bg_red;
                Green   <= '0;
                Blue    <= COLOR_W'(8'h44);
                hit_idx <= NO_HIT;
            end
        end
    end

`ifdef COLLISION_DETECT_EN
    logic multi_hit;

    assign multi_hit = (hit_s1 & (hit_s1 - NUM_SPRITES'(1))) != '0;

    // Frame start clears even when an overlap is being flagged in the same cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            collision_mask <= '0;
        else if (frame_start)
            collision_mask <= '0;
        else if (valid_s1 && multi_hit)
            collision_mask <= collision_mask | hit_s1;
    end
`endif

endmodule
